// File: rtl/vga_line_fetch_scheduler.sv
// Paces line loads into the scan-out FIFO: one request per line, issued when
// the FIFO has room for a full line, with frame restarts deferred past in-flight loads.
module vga_line_fetch_scheduler #(
  parameter int H_PIXELS   = 1280,
  parameter int V_LINES    = 1024,
  parameter int FIFO_DEPTH = 2048,
  parameter int REQ_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFRAME_START,
  input  logic        iFIFO_WEN,
  input  logic [11:0] iFIFO_WRUSEDW,
  output logic [12:0] oVGA_LINE_TO_LOAD,
  output logic        oVGA_LOAD_TO_FIFO_REQ,
  output logic        oBUSY,
  output logic        oFRAME_LOADED,
  output logic        oLATE,
  output logic        oBEAT_ERR
);

  localparam int RC_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(REQ_CYCLES - 1);
  localparam logic [12:0]     LAST_BEAT = 13'(H_PIXELS - 1);
  localparam logic [12:0]     LINES     = 13'(V_LINES);
  localparam logic [12:0]     LINE_LEN  = 13'(H_PIXELS);
  localparam logic [12:0]     DEPTH     = 13'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_LOAD      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [12:0]     line_cnt_q, line_cnt_d;
  logic [12:0]     beat_cnt_q, beat_cnt_d;
  logic [RC_W-1:0] req_cnt_q, req_cnt_d;
  logic            pending_q, pending_d;
  logic [12:0]     line_out_q, line_out_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            loaded_q, loaded_d;
  logic            late_q, late_d;
  logic            beat_err_q, beat_err_d;

  logic [12:0]     free_space;
  logic            last_beat;

  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    beat_cnt_d = beat_cnt_q;
    req_cnt_d  = req_cnt_q;
    pending_d  = pending_q;
    line_out_d = line_out_q;
    loaded_d   = loaded_q;
    late_d     = late_q;
    // Any beat arriving outside LOAD is flagged and otherwise ignored.
    beat_err_d = beat_err_q | (iFIFO_WEN && (state_q != ST_LOAD));
    free_space = DEPTH - {1'b0, iFIFO_WRUSEDW};
    last_beat  = iFIFO_WEN && (beat_cnt_q == LAST_BEAT);

    case (state_q)
      ST_IDLE: begin
        if (iFRAME_START) begin
          line_cnt_d = '0;
          loaded_d   = 1'b0;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (iFRAME_START) begin
          line_cnt_d = '0;
          late_d     = 1'b1;
        end else if (line_cnt_q == LINES) begin
          loaded_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (free_space >= LINE_LEN) begin
          line_out_d = line_cnt_q;
          req_cnt_d  = '0;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        if (iFRAME_START) begin
          pending_d = 1'b1;
          late_d    = 1'b1;
        end
        if (req_cnt_q == RC_LAST) begin
          state_d = ST_WAIT_DROP;
        end else begin
          req_cnt_d = req_cnt_q + RC_W'(1);
        end
      end

      ST_WAIT_DROP: begin
        if (iFRAME_START) begin
          pending_d = 1'b1;
          late_d    = 1'b1;
        end
        beat_cnt_d = '0;
        state_d    = ST_LOAD;
      end

      ST_LOAD: begin
        if (iFRAME_START) begin
          pending_d = 1'b1;
          late_d    = 1'b1;
        end
        // The loader cannot be cancelled, so a restart lands only once the line is done.
        if (last_beat) begin
          beat_cnt_d = '0;
          line_cnt_d = (pending_q || iFRAME_START) ? 13'd0 : line_cnt_q + 13'd1;
          pending_d  = 1'b0;
          state_d    = ST_CHECK;
        end else if (iFIFO_WEN) begin
          beat_cnt_d = beat_cnt_q + 13'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_d  = (state_d == ST_REQ);
    busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT_DROP) || (state_d == ST_LOAD);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      line_cnt_q <= '0;
      beat_cnt_q <= '0;
      req_cnt_q  <= '0;
      pending_q  <= 1'b0;
      line_out_q <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      late_q     <= 1'b0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      req_cnt_q  <= req_cnt_d;
      pending_q  <= pending_d;
      line_out_q <= line_out_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      late_q     <= late_d;
      beat_err_q <= beat_err_d;
    end
  end

  assign oVGA_LINE_TO_LOAD     = line_out_q;
  assign oVGA_LOAD_TO_FIFO_REQ = req_q;
  assign oBUSY                 = busy_q;
  assign oFRAME_LOADED         = loaded_q;
  assign oLATE                 = late_q;
  assign oBEAT_ERR             = beat_err_q;

endmodule
